// File: rtl/y_diag_update_seq.sv
// Sequencer that drives the diagonal-update datapath's operand buses and selects, then returns y_new_diag.
// Optional macro YDC_NOP_BYPASS_EN: op 00 returns req_y_diag directly without touching the datapath.
module y_diag_update_seq #(
    parameter int WIDTH  = 48,
    parameter int IDX_W  = 8,
    parameter int DP_LAT = 2
) (
    input  logic             clock,
    input  logic             reset,
    // Handshakes: a transfer happens on a rising edge where valid & ready; valid holds its payload until then.
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [IDX_W-1:0] req_idx,
    input  logic [WIDTH-1:0] req_y_diag,
    input  logic [WIDTH-1:0] req_y_old,
    input  logic [WIDTH-1:0] req_y_new,
    output logic [WIDTH-1:0] y_diag,
    output logic [WIDTH-1:0] y_old,
    output logic [WIDTH-1:0] y_new,
    output logic [1:0]       sel_old_or_new,
    output logic             sel_diag_or_sum,
    output logic             sel_mode_addsub,
    input  logic [WIDTH-1:0] y_new_diag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [IDX_W-1:0] res_idx,
    output logic [WIDTH-1:0] res_y_diag,
    output logic             busy,
    output logic [2:0]       o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_P1   = 3'd2,
        S_P2   = 3'd3,
        S_WAIT = 3'd4,
        S_OUT  = 3'd5
    } state_t;

    localparam logic [1:0] OP_ADD    = 2'b01;
    localparam logic [1:0] OP_REMOVE = 2'b10;
    localparam logic [1:0] OP_CHANGE = 2'b11;
    localparam logic [3:0] CNT_LAST  = 4'(DP_LAT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_cnt;
    logic [1:0]       r_op;
    logic [IDX_W-1:0] r_idx;
    logic             w_accept;
    logic             w_bypass;
    logic             w_cnt_last;
    logic             w_wait_last;

    assign w_accept    = req_valid && (r_state == S_IDLE);
    assign w_cnt_last  = (r_cnt == CNT_LAST);
    // Only the two-pass change op needs the full settle time after P2; single-pass ops settled during P1.
    assign w_wait_last = (r_op != OP_CHANGE) || w_cnt_last;

`ifdef YDC_NOP_BYPASS_EN
    assign w_bypass = w_accept && (req_op == 2'b00);
`else
    assign w_bypass = 1'b0;
`endif

    assign req_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign res_valid   = (r_state == S_OUT);
    assign o_dbg_state = r_state;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state != w_next) ? 4'd0 : r_cnt + 4'd1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_bypass ? S_OUT : S_LOAD;
            S_LOAD: w_next = S_P1;
            S_P1:   if (w_cnt_last) w_next = (r_op == OP_CHANGE) ? S_P2 : S_WAIT;
            S_P2:   w_next = S_WAIT;
            S_WAIT: if (w_wait_last) w_next = S_OUT;
            S_OUT:  if (res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // HOLD (add zero to feedback) everywhere except the two active passes.
    always_comb begin
        sel_old_or_new  = 2'b01;
        sel_diag_or_sum = 1'b1;
        sel_mode_addsub = 1'b0;
        case (r_state)
            S_P1: begin
                sel_diag_or_sum = 1'b0;
                case (r_op)
                    OP_REMOVE, OP_CHANGE: begin
                        sel_old_or_new  = 2'b11;
                        sel_mode_addsub = 1'b1;
                    end
                    OP_ADD:  sel_old_or_new = 2'b00;
                    default: sel_old_or_new = 2'b01;
                endcase
            end
            S_P2: begin
                sel_diag_or_sum = 1'b1;
                sel_old_or_new  = 2'b00;
                sel_mode_addsub = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            y_diag     <= '0;
            y_old      <= '0;
            y_new      <= '0;
            r_op       <= 2'b00;
            r_idx      <= '0;
            res_y_diag <= '0;
            res_idx    <= '0;
        end else begin
            if (w_accept) begin
                y_diag <= req_y_diag;
                y_old  <= req_y_old;
                y_new  <= req_y_new;
                r_op   <= req_op;
                r_idx  <= req_idx;
            end
            if (w_bypass) begin
                res_y_diag <= req_y_diag;
                res_idx    <= req_idx;
            end else if ((r_state == S_WAIT) && w_wait_last) begin
                res_y_diag <= y_new_diag;
                res_idx    <= r_idx;
            end
        end
    end

endmodule

// File: doc/y_diag_update_seq.md
Name: y_diag_update_seq

Overview:
- Upstream sequencer for update_y_diagonal_calc.
- Accepts one diagonal-update request (bus index, current diagonal admittance, old and new line admittance) over a valid/ready handshake.
- Drives the datapath's operand buses and select lines for the required add/subtract passes, captures y_new_diag at the exact settle cycle and returns it on a valid/ready result port.
- Bridges the Y-bus memory reader to the diagonal-update datapath.

Parameters:
- WIDTH, 48, packed complex admittance width (real upper half, imag lower half); opaque to this block.
- IDX_W, 8, bus index tag width.
- DP_LAT, 2, cycles from a select-line change to y_new_diag reflecting it (adder latency + output register); legal 1..15.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  high only in IDLE
- req_op  input  2  00 nop, 01 add line, 10 remove line, 11 change line
- req_idx  input  IDX_W  bus index tag
- req_y_diag / req_y_old / req_y_new  input  WIDTH  operands
- y_diag / y_old / y_new  output  WIDTH  to datapath; registered, held for the whole operation
- sel_old_or_new  output  2  00 = y_new, 11 = y_old, 01 = zero
- sel_diag_or_sum  output  1  0 = diag, 1 = feedback y_new_diag
- sel_mode_addsub  output  1  0 = add, 1 = subtract
- y_new_diag  input  WIDTH  datapath result
- res_valid  output  1  result pending
- res_ready  input  1  consumer accepts
- res_idx  output  IDX_W  tag of result
- res_y_diag  output  WIDTH  updated diagonal
- busy  output  1  state != IDLE

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE; y_* outputs, res_y_diag and res_idx = 0; res_valid = 0; selects at HOLD setting (sel_old_or_new=01, sel_diag_or_sum=1, mode=0). Reset mid-operation aborts and discards the operation with no result.
- HOLD setting: adds zero to feedback, so the datapath keeps its value. Driven in IDLE, LOAD, WAIT and OUT.
- States: IDLE -> LOAD -> P1 -> {P2 -> WAIT} or {WAIT} -> OUT -> IDLE.
- Accept on req_valid & req_ready. At the accept edge, register op, idx and the three operands onto the y_* outputs. req_ready=0 in every state except IDLE.
- LOAD: 1 cycle, so the datapath input registers capture the operands.
- P1: held DP_LAT cycles using a cycle counter.
  - op 10 and op 11: sel_diag_or_sum=0, sel_old_or_new=11, mode=1.
  - op 01: sel_diag_or_sum=0, sel_old_or_new=00, mode=0.
  - op 00 without macro: sel_diag_or_sum=0, sel_old_or_new=01, mode=0.
- P2 (op 11 only): exactly one cycle of sel_diag_or_sum=1, sel_old_or_new=00, mode=0. Must not be held longer, because the feedback would accumulate or be overwritten by stale results.
- WAIT:
  - After P2: HOLD for DP_LAT cycles.
  - Single-pass ops: 1 cycle.
  - On the final WAIT cycle, capture y_new_diag into res_y_diag and idx into res_idx.
- OUT: res_valid=1, held stable until res_ready; on res_valid & res_ready go to IDLE.
- Latency, counted as cycle N after the accept edge in which res_valid first goes high:
  - single-pass: N = DP_LAT+3
  - op 11: N = 2*DP_LAT+3
  - DP_LAT=2: 5 and 7 respectively.
- Throughput: at most one operation in flight. The next accept can occur the cycle after the result handshake.
- The block performs no arithmetic; wrap behaviour is the datapath's.

Optional Feature:
- Macro: YDC_NOP_BYPASS_EN.
- Defined: op 00 skips LOAD/P1/WAIT. At the accept edge res_y_diag = req_y_diag and res_idx is captured; res_valid is high in cycle N=1. The datapath selects stay at HOLD.
- Undefined: op 00 runs as a single-pass add of zero; N = DP_LAT+3; result = y_diag via the datapath.

Test Plan:
- Reset with DP_LAT=2, then reset held low 3 cycles -> req_ready=1, res_valid=0, selects 01/1/0, all data outputs 0.
- op 11, diag=0x000064_000032, old=0x00000A_000005, new=0x000014_000003, idx=7, with a behavioural update_y_diagonal_calc -> res_valid in cycle 7, res_y_diag=0x00006E_000030, res_idx=7; sel_old_or_new=00 for exactly one cycle.
- op 01 and op 10 with the same operands -> cycle 5 results 0x000078_000035 and 0x00005A_00002D respectively.
- res_ready held low 4 cycles after res_valid, with req_valid high throughout -> res_valid and res_y_diag stable, req_ready=0, no second accept until the cycle after the handshake.
- reset driven low in P2 of an op 11 -> no res_valid, state IDLE next cycle; a new op 01 afterwards completes correctly in cycle 5.
- op 00, diag=0x000123_000456 -> with macro: res_valid in cycle 1; without: cycle 5; both return 0x000123_000456.
